// File: rtl/md_pkg.sv
// Shared types and default sizing for the MD force-core broadcast controller.
package md_pkg;

  localparam int NUM_CELLS = 8;
  localparam int ID_W      = 7;

  typedef logic [ID_W-1:0] particle_id_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_WAIT  = 3'd1,
    READ_NUM    = 3'd2,
    READING     = 3'd3,
    PHASE_DRAIN = 3'd4,
    REF_DRAIN   = 3'd5
  } bc_state_t;

endpackage

// File: rtl/multi_phase_broadcast_ctrl_if.sv
// Scheduler / cell-reader side bundle of the broadcast controller.
interface multi_phase_broadcast_ctrl_if #(
  parameter int NUM_CELLS  = md_pkg::NUM_CELLS,
  parameter int ID_W       = md_pkg::ID_W,
  parameter int NUM_PHASES = 2
);
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int DC_W = $clog2(NUM_CELLS) + 1;

  logic                      iter_start;
  logic                      abort;
  logic [NUM_CELLS-1:0]      cell_enable;
  logic [NUM_CELLS*ID_W-1:0] particle_num;
  logic [NUM_CELLS-1:0]      back_pressure;
  logic [NUM_CELLS-1:0]      filter_buffer_empty;
  logic [NUM_CELLS-1:0]      reading_done;
  logic                      all_force_wr_issued;
  logic                      all_ref_wb_issued;
  logic [DC_W-1:0]           drain_counter;
  logic [ID_W-1:0]           particle_id;
  logic [ID_W-1:0]           ref_id;
  logic [PH_W-1:0]           phase;
  logic                      reading_particle_num;
  logic                      pause_reading;
  logic                      goto_next_ref;
  logic                      all_reading_done;
  logic                      all_filter_buffer_empty;
  logic                      iter_done;
  logic                      busy;

  modport master (
    input  iter_start, abort, cell_enable, particle_num, back_pressure,
           filter_buffer_empty, reading_done, all_force_wr_issued,
           all_ref_wb_issued, drain_counter,
    output particle_id, ref_id, phase, reading_particle_num, pause_reading,
           goto_next_ref, all_reading_done, all_filter_buffer_empty,
           iter_done, busy
  );

  modport slave (
    output iter_start, abort, cell_enable, particle_num, back_pressure,
           filter_buffer_empty, reading_done, all_force_wr_issued,
           all_ref_wb_issued, drain_counter,
    input  particle_id, ref_id, phase, reading_particle_num, pause_reading,
           goto_next_ref, all_reading_done, all_filter_buffer_empty,
           iter_done, busy
  );

endinterface

// File: rtl/bc_cell_status.sv
// Per-cell done comparisons and enable-masked reductions over all cells.
module bc_cell_status #(
  parameter int NUM_CELLS = md_pkg::NUM_CELLS,
  parameter int ID_W      = md_pkg::ID_W
) (
  input  logic [ID_W-1:0]           particle_id,
  input  logic [NUM_CELLS*ID_W-1:0] particle_num,
  input  logic [NUM_CELLS-1:0]      cell_enable,
  input  logic [NUM_CELLS-1:0]      back_pressure,
  input  logic [NUM_CELLS-1:0]      filter_buffer_empty,
  input  logic [NUM_CELLS-1:0]      reading_done,
  output logic                      all_bcast_done,
  output logic                      bp,
  output logic                      all_reading_done,
  output logic                      all_filter_buffer_empty
);

  logic [NUM_CELLS-1:0] cell_done_s;

  // A disabled cell is always done; an enabled one once the ID passes its count.
  always_comb begin
    cell_done_s = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cell_done_s[i] = ~cell_enable[i] | (particle_id > particle_num[i*ID_W +: ID_W]);
    end
  end

  assign all_bcast_done          = &cell_done_s;
  assign bp                      = |(back_pressure & cell_enable);
  assign all_reading_done        = &(reading_done | ~cell_enable);
  assign all_filter_buffer_empty = &(filter_buffer_empty | ~cell_enable);

endmodule

// File: rtl/multi_phase_broadcast_ctrl.sv
// Sequences reference-particle broadcast over all cells and neighbour phases.
module multi_phase_broadcast_ctrl #(
  parameter int NUM_CELLS   = md_pkg::NUM_CELLS,
  parameter int ID_W        = md_pkg::ID_W,
  parameter int NUM_PHASES  = 2,
  parameter int START_DELAY = 10,
  parameter int PIPE_DEPTH  = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_phase_broadcast_ctrl_if.master  bus
);
  import md_pkg::*;

  localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int DC_W  = $clog2(NUM_CELLS) + 1;
  localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int THR   = (NUM_CELLS > PIPE_DEPTH) ? (NUM_CELLS - PIPE_DEPTH) : 0;

  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [DC_W-1:0]  DRAIN_THR  = DC_W'(THR);
  localparam logic [ID_W-1:0]  ID_MAX     = {ID_W{1'b1}};

  bc_state_t        state_r;
  logic [CNT_W-1:0] delay_cnt_r;
  logic [ID_W-1:0]  particle_id_r;
  logic [ID_W-1:0]  ref_id_r;
  logic [PH_W-1:0]  phase_r;
  logic             pause_r;
  logic             read_num_r;
  logic             goto_next_ref_r;
  logic             iter_done_r;
  logic             busy_r;
  logic             inc_pending_r;

  logic all_bcast_done_s;
  logic bp_s;
  logic all_reading_done_s;
  logic all_fbe_s;

  bc_cell_status #(
    .NUM_CELLS (NUM_CELLS),
    .ID_W      (ID_W)
  ) u_cell_status (
    .particle_id             (particle_id_r),
    .particle_num            (bus.particle_num),
    .cell_enable             (bus.cell_enable),
    .back_pressure           (bus.back_pressure),
    .filter_buffer_empty     (bus.filter_buffer_empty),
    .reading_done            (bus.reading_done),
    .all_bcast_done          (all_bcast_done_s),
    .bp                      (bp_s),
    .all_reading_done        (all_reading_done_s),
    .all_filter_buffer_empty (all_fbe_s)
  );

  // Broadcast sequencer; abort shares the reset path so it wins over every transition.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state_r         <= IDLE;
      delay_cnt_r     <= '0;
      particle_id_r   <= '0;
      ref_id_r        <= ID_W'(1);
      phase_r         <= '0;
      pause_r         <= 1'b1;
      read_num_r      <= 1'b0;
      goto_next_ref_r <= 1'b0;
      iter_done_r     <= 1'b0;
      busy_r          <= 1'b0;
      inc_pending_r   <= 1'b0;
    end else begin
      goto_next_ref_r <= 1'b0;
      iter_done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.iter_start) begin
            state_r     <= START_WAIT;
            busy_r      <= 1'b1;
            delay_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        START_WAIT: begin
          if (delay_cnt_r == DELAY_LAST) begin
            state_r     <= READ_NUM;
            delay_cnt_r <= '0;
            read_num_r  <= 1'b1;
            pause_r     <= 1'b0;
          end else begin
            delay_cnt_r <= delay_cnt_r + CNT_W'(1);
          end
        end
        READ_NUM: begin
          particle_id_r <= ID_W'(1);
          read_num_r    <= 1'b0;
          state_r       <= READING;
        end
        READING: begin
          if (all_bcast_done_s) begin
            particle_id_r <= ID_W'(1);
            pause_r       <= 1'b1;
            if (phase_r < PH_LAST) begin
              state_r <= PHASE_DRAIN;
            end else begin
              state_r       <= REF_DRAIN;
              inc_pending_r <= 1'b1;
            end
          end else if (bp_s) begin
            pause_r <= 1'b1;
          end else begin
            particle_id_r <= particle_id_r + ID_W'(1);
            pause_r       <= 1'b0;
          end
        end
        PHASE_DRAIN: begin
          if (all_fbe_s) begin
            phase_r         <= phase_r + PH_W'(1);
            pause_r         <= 1'b0;
            goto_next_ref_r <= 1'b1;
            state_r         <= READING;
          end else begin
            state_r <= PHASE_DRAIN;
          end
        end
        REF_DRAIN: begin
          // The ref_id bump clears inc_pending, so the advance branch can only follow it.
          if (all_reading_done_s && bus.all_force_wr_issued) begin
            state_r       <= IDLE;
            delay_cnt_r   <= '0;
            particle_id_r <= '0;
            ref_id_r      <= ID_W'(1);
            phase_r       <= '0;
            pause_r       <= 1'b1;
            read_num_r    <= 1'b0;
            busy_r        <= 1'b0;
            inc_pending_r <= 1'b0;
            iter_done_r   <= 1'b1;
          end else if (all_reading_done_s) begin
            state_r <= REF_DRAIN;
          end else if (inc_pending_r && all_fbe_s) begin
            if (ref_id_r != ID_MAX) begin
              ref_id_r <= ref_id_r + ID_W'(1);
            end else begin
              ref_id_r <= ref_id_r;
            end
            inc_pending_r <= 1'b0;
          end else if (!inc_pending_r && bus.all_ref_wb_issued &&
                       (bus.drain_counter > DRAIN_THR)) begin
            phase_r         <= '0;
            pause_r         <= 1'b0;
            goto_next_ref_r <= 1'b1;
            state_r         <= READING;
          end else begin
            state_r <= REF_DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.particle_id             = particle_id_r;
  assign bus.ref_id                  = ref_id_r;
  assign bus.phase                   = phase_r;
  assign bus.reading_particle_num    = read_num_r;
  assign bus.pause_reading           = pause_r;
  assign bus.goto_next_ref           = goto_next_ref_r;
  assign bus.all_reading_done        = all_reading_done_s;
  assign bus.all_filter_buffer_empty = all_fbe_s;
  assign bus.iter_done               = iter_done_r;
  assign bus.busy                    = busy_r;

endmodule

// File: tb/tb_multi_phase_broadcast_ctrl.sv
// Directed bench for multi_phase_broadcast_ctrl with hand-computed expectations.
module tb_multi_phase_broadcast_ctrl;

  localparam int NC = 4;
  localparam int IW = 8;
  localparam int NP = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  multi_phase_broadcast_ctrl_if #(.NUM_CELLS(NC), .ID_W(IW), .NUM_PHASES(NP)) bus ();

  multi_phase_broadcast_ctrl #(
    .NUM_CELLS   (NC),
    .ID_W        (IW),
    .NUM_PHASES  (NP),
    .START_DELAY (10),
    .PIPE_DEPTH  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse iter_start, then walk the start delay; leaves the DUT in READING at particle_id 1.
  task automatic start_iter();
    bus.iter_start = 1'b1;
    tick();
    bus.iter_start = 1'b0;
    check_val("start_busy", bus.busy, 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_val("rpn_window", bus.reading_particle_num, (k == 10) ? 1 : 0);
      if (k == 10) begin
        check_val("rpn_pid0", bus.particle_id, 0);
        check_val("rpn_unpause", bus.pause_reading, 0);
      end
    end
    check_val("first_pid", bus.particle_id, 1);
  endtask

  // Step particle_id from first to last, then expect the drain entry with particle_id 1.
  task automatic run_phase(input int first, input int last);
    for (int p = first + 1; p <= last; p++) begin
      tick();
      check_val("pid_step", bus.particle_id, p);
    end
    tick();
    check_val("drain_pid", bus.particle_id, 1);
    check_val("drain_pause", bus.pause_reading, 1);
  endtask

  initial begin
    n_checks                = 0;
    n_fail                  = 0;
    rst                     = 1'b1;
    bus.iter_start          = 1'b0;
    bus.abort               = 1'b0;
    bus.cell_enable         = 4'hF;
    bus.particle_num        = {8'd3, 8'd5, 8'd2, 8'd4};
    bus.back_pressure       = 4'h0;
    bus.filter_buffer_empty = 4'h0;
    bus.reading_done        = 4'h0;
    bus.all_force_wr_issued = 1'b0;
    bus.all_ref_wb_issued   = 1'b0;
    bus.drain_counter       = 3'd0;
    repeat (3) tick();
    rst = 1'b0;

    check_val("rst_pid", bus.particle_id, 0);
    check_val("rst_ref", bus.ref_id, 1);
    check_val("rst_phase", bus.phase, 0);
    check_val("rst_pause", bus.pause_reading, 1);
    check_val("rst_rpn", bus.reading_particle_num, 0);
    check_val("rst_goto", bus.goto_next_ref, 0);
    check_val("rst_done", bus.iter_done, 0);
    check_val("rst_busy", bus.busy, 0);

    // Start timing and phase 0 sweep.
    start_iter();
    run_phase(1, 6);
    check_val("pd_phase", bus.phase, 0);
    tick();
    check_val("pd_hold_phase", bus.phase, 0);
    check_val("pd_hold_goto", bus.goto_next_ref, 0);
    bus.filter_buffer_empty = 4'hF;
    tick();
    check_val("pd_exit_phase", bus.phase, 1);
    check_val("pd_exit_goto", bus.goto_next_ref, 1);
    check_val("pd_exit_pause", bus.pause_reading, 0);
    check_val("pd_exit_pid", bus.particle_id, 1);
    bus.filter_buffer_empty = 4'h0;

    // Stall on an enabled cell, then the same request on a masked cell.
    tick();
    check_val("p1_pid2", bus.particle_id, 2);
    check_val("p1_goto_clr", bus.goto_next_ref, 0);
    tick();
    check_val("p1_pid3", bus.particle_id, 3);
    bus.back_pressure = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_val("stall_pid", bus.particle_id, 3);
      check_val("stall_pause", bus.pause_reading, 1);
    end
    bus.back_pressure = 4'b0000;
    tick();
    check_val("resume_pid", bus.particle_id, 4);
    check_val("resume_pause", bus.pause_reading, 0);
    bus.cell_enable   = 4'b1011;
    bus.back_pressure = 4'b0100;
    tick();
    check_val("masked_bp_pid", bus.particle_id, 5);
    check_val("masked_bp_pause", bus.pause_reading, 0);
    bus.cell_enable   = 4'hF;
    bus.back_pressure = 4'b0000;
    run_phase(5, 6);
    check_val("rd_phase", bus.phase, 1);

    // Ref advance: increment must land before goto_next_ref, threshold is strict.
    tick();
    check_val("rd_wait_ref", bus.ref_id, 1);
    bus.all_ref_wb_issued = 1'b1;
    bus.drain_counter     = 3'd3;
    tick();
    check_val("rd_noinc_ref", bus.ref_id, 1);
    check_val("rd_noinc_goto", bus.goto_next_ref, 0);
    bus.filter_buffer_empty = 4'hF;
    bus.drain_counter       = 3'd2;
    tick();
    check_val("rd_inc_ref", bus.ref_id, 2);
    check_val("rd_inc_goto", bus.goto_next_ref, 0);
    tick();
    check_val("rd_thr_goto", bus.goto_next_ref, 0);
    check_val("rd_thr_phase", bus.phase, 1);
    bus.drain_counter = 3'd3;
    tick();
    check_val("adv_goto", bus.goto_next_ref, 1);
    check_val("adv_ref", bus.ref_id, 2);
    check_val("adv_phase", bus.phase, 0);
    check_val("adv_pause", bus.pause_reading, 0);
    check_val("adv_pid", bus.particle_id, 1);

    // Iteration end after a held force flush.
    run_phase(1, 6);
    tick();
    check_val("r2_phase1", bus.phase, 1);
    check_val("r2_goto", bus.goto_next_ref, 1);
    run_phase(1, 6);
    bus.reading_done        = 4'hF;
    bus.all_force_wr_issued = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check_val("end_hold_done", bus.iter_done, 0);
      check_val("end_hold_ref", bus.ref_id, 2);
      check_val("end_hold_busy", bus.busy, 1);
    end
    bus.all_force_wr_issued = 1'b1;
    tick();
    check_val("end_pulse", bus.iter_done, 1);
    check_val("end_busy", bus.busy, 0);
    check_val("end_ref", bus.ref_id, 1);
    check_val("end_phase", bus.phase, 0);
    check_val("end_pid", bus.particle_id, 0);
    check_val("end_pause", bus.pause_reading, 1);
    bus.all_force_wr_issued = 1'b0;
    bus.reading_done        = 4'h0;
    tick();
    check_val("end_pulse_clr", bus.iter_done, 0);
    check_val("end_idle_busy", bus.busy, 0);

    // Mid-iteration iter_start is ignored; abort returns to idle without iter_done.
    bus.filter_buffer_empty = 4'h0;
    start_iter();
    tick();
    check_val("ab_pid2", bus.particle_id, 2);
    bus.iter_start = 1'b1;
    tick();
    bus.iter_start = 1'b0;
    check_val("ign_pid", bus.particle_id, 3);
    check_val("ign_rpn", bus.reading_particle_num, 0);
    check_val("ign_busy", bus.busy, 1);
    tick();
    check_val("ab_pid4", bus.particle_id, 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("ab_pid", bus.particle_id, 0);
    check_val("ab_busy", bus.busy, 0);
    check_val("ab_pause", bus.pause_reading, 1);
    check_val("ab_ref", bus.ref_id, 1);
    check_val("ab_done", bus.iter_done, 0);
    tick();
    check_val("ab_stay_busy", bus.busy, 0);
    check_val("ab_stay_done", bus.iter_done, 0);

    // All cells masked: one READING cycle per phase.
    bus.cell_enable = 4'h0;
    start_iter();
    tick();
    check_val("m_pd_pause", bus.pause_reading, 1);
    check_val("m_pd_phase", bus.phase, 0);
    tick();
    check_val("m_ph1", bus.phase, 1);
    check_val("m_ph1_goto", bus.goto_next_ref, 1);
    tick();
    check_val("m_rd_pause", bus.pause_reading, 1);
    check_val("m_rd_goto", bus.goto_next_ref, 0);
    tick();
    check_val("m_hold_busy", bus.busy, 1);
    check_val("m_hold_done", bus.iter_done, 0);
    check_val("m_all_rd", bus.all_reading_done, 1);
    check_val("m_all_fbe", bus.all_filter_buffer_empty, 1);
    bus.all_force_wr_issued = 1'b1;
    tick();
    check_val("m_done", bus.iter_done, 1);
    check_val("m_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_phase_broadcast_ctrl.md
Name: multi_phase_broadcast_ctrl

Overview:
Parametrised next-generation broadcast controller for the MD force core. It sequences reference-particle broadcast over NUM_CELLS cell memories across NUM_PHASES neighbour phases, with a programmable start delay and drain threshold. Adds per-cell enable masking, synchronous abort, an iteration-done pulse and a busy flag. It sits between the iteration scheduler and the per-cell position readers / filter buffers.

Parameters:
NUM_CELLS, 8, number of cells/PEs driven.
ID_W, 7, particle/ref ID width.
NUM_PHASES, 2, neighbour phases per ref ID (min 1).
START_DELAY, 10, idle cycles after iter_start before the particle-count read (min 1).
PIPE_DEPTH, 31, force pipeline depth used for the ring drain threshold.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iter_start  in  1  start iteration; sampled only in IDLE
abort  in  1  synchronous return to IDLE
cell_enable  in  NUM_CELLS  1 = cell participates; masked cells count as done/empty/no back-pressure
particle_num  in  NUM_CELLS*ID_W  particle count per cell
back_pressure  in  NUM_CELLS  per-cell stall request
filter_buffer_empty  in  NUM_CELLS  per-cell filter empty
reading_done  in  NUM_CELLS  per-cell: ref ID exceeded particle count
all_force_wr_issued  in  1  all force writes flushed
all_ref_wb_issued  in  1  reference writeback issued
drain_counter  in  $clog2(NUM_CELLS)+1  ring drain cycle count
particle_id  out  ID_W  broadcast neighbour ID
ref_id  out  ID_W  current reference ID
phase  out  max(1,$clog2(NUM_PHASES))  current phase
reading_particle_num  out  1  data on bus is the particle count
pause_reading  out  1  invalidate reads
goto_next_ref  out  1  one-cycle pulse on entering READING from a drain state
all_reading_done  out  1  masked AND of reading_done
all_filter_buffer_empty  out  1  masked AND of filter_buffer_empty
iter_done  out  1  one-cycle pulse at iteration end
busy  out  1  high whenever not in IDLE

Behaviour:
- Reset and abort values: state IDLE, ref_id=1, phase=0, particle_id=0, pause_reading=1, reading_particle_num=0, goto_next_ref=0, iter_done=0, busy=0, delay counter=0, inc_pending=0. Abort has priority over all other transitions; no iter_done is produced on abort.
- Masked reductions are combinational. cell_done[i] = ~cell_enable[i] | (particle_id > particle_num[i]). all_bcast_done = AND of cell_done. bp = OR of (back_pressure & cell_enable).
- IDLE: on iter_start go to START_WAIT, busy<=1. iter_start is ignored in all other states.
- START_WAIT: counter++. When counter==START_DELAY-1, go to READ_NUM with reading_particle_num<=1, pause_reading<=0. If iter_start is high in cycle 0, reading_particle_num is high for exactly cycle START_DELAY+1 while particle_id=0.
- READ_NUM: particle_id<=1, reading_particle_num<=0, go to READING.
- READING: goto_next_ref<=0.
  - If all_bcast_done: particle_id<=1, pause<=1. If phase<NUM_PHASES-1, go to PHASE_DRAIN; otherwise go to REF_DRAIN with inc_pending<=1.
  - Else if bp: hold particle_id, pause<=1.
  - Else: particle_id++, pause<=0.
- PHASE_DRAIN: when all_filter_buffer_empty, phase++, pause<=0, goto_next_ref<=1, go to READING. Otherwise hold.
- REF_DRAIN, in priority order:
  - If all_reading_done & all_force_wr_issued: go to IDLE with reset values, iter_done<=1.
  - Else if all_reading_done: hold.
  - Else if inc_pending & all_filter_buffer_empty: ref_id++ (saturating at 2^ID_W-1), inc_pending<=0.
  - Else if ~inc_pending & all_ref_wb_issued & drain_counter > THR: phase<=0, pause<=0, goto_next_ref<=1, go to READING. THR = NUM_CELLS-PIPE_DEPTH if NUM_CELLS>PIPE_DEPTH, else 0.
  - A ref advance never precedes its ref_id increment.
- particle_num values must be ≤ 2^ID_W-2, so particle_id never wraps.
- With all cells masked, all_bcast_done is immediately true: each phase runs a single READING cycle.
- NUM_PHASES=1: READING goes directly to REF_DRAIN.

Decomposition:
- md_pkg holds NUM_CELLS, ID_W, particle_id_t and the bc_state_t enum (IDLE, START_WAIT, READ_NUM, READING, PHASE_DRAIN, REF_DRAIN).
- One sub-module, bc_cell_status, computes the masked reductions and the per-cell done comparisons.

Test Plan:
All scenarios use NUM_CELLS=4, NUM_PHASES=2, START_DELAY=10, PIPE_DEPTH=2, ID_W=8.
1. Start timing: particle_num={3,5,2,4}, all enabled, iter_start high in cycle 0 -> reading_particle_num high only in cycle 11; particle_id steps 1..6; PHASE_DRAIN entered with particle_id=1.
2. Stall: hold back_pressure[2] high for 3 cycles at particle_id=3 -> particle_id stays 3 and pause_reading=1 for 3 cycles, then resumes at 4. Repeat with cell_enable[2]=0 -> no stall.
3. Phase and ref advance: filter buffers empty, all_ref_wb_issued=1, drain_counter=3 (THR=2) -> ref_id goes 1→2 before goto_next_ref pulses; phase returns to 0. With drain_counter=2, the controller stays in REF_DRAIN.
4. Iteration end: reading_done=4'hF with all_force_wr_issued=0 for 5 cycles, then 1 -> exactly one iter_done pulse; outputs return to ref_id=1, phase=0, particle_id=0, busy=0.
5. Abort in READING at particle_id=4 -> next cycle IDLE with reset values and no iter_done. iter_start asserted mid-iteration -> ignored.
6. Degenerate masking: cell_enable=0 -> each phase lasts one READING cycle; the iteration completes once all_force_wr_issued=1.
